// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int KEY_CODE_W = 8;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_ACK     = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  function automatic logic [KEY_CODE_W-1:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {4'h0, row, col};
  endfunction

  // Lowest-index low row wins when several keys share a column.
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [COLS-1:0] col_drive(input logic [1:0] col);
    return ~(COLS'(1) << col);
  endfunction
endpackage

// File: rtl/keypad_stable_cnt.sv
// Saturating run-length counter: done after N consecutive match clocks.
module keypad_stable_cnt #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic match,
  output logic done
);
  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] LIM = W'(N);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || !match) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + ONE;
    end
  end

  assign done = (cnt == LIM);
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner/debouncer feeding a send/ack handshake.
// Define KEYPAD_REPEAT_EN to generate auto-repeat events while a key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int CLK_PER_SCAN    = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROWS-1:0]       i_row,
  output logic [COLS-1:0]       o_col,
  input  logic                  i_proc,
  output logic                  o_send,
  output logic [KEY_CODE_W-1:0] o_data,
  output logic                  o_key_down
);
  localparam int SCAN_W = $clog2(CLK_PER_SCAN + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CLK_PER_SCAN - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

  if (CLK_PER_SCAN < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("keypad_scan: illegal parameter value");
  end

  state_t            state;
  logic [ROWS-1:0]   row_s1, row_s2, pat;
  logic [1:0]        col, row_idx;
  logic [SCAN_W-1:0] scan_cnt;
  logic              press_done, rel_done, rep_done;

  keypad_stable_cnt #(.N(DEBOUNCE_CYCLES)) u_press (
    .clk(clk), .rst(rst), .clear(state != DEBOUNCE), .match(row_s2 == pat), .done(press_done)
  );

  keypad_stable_cnt #(.N(DEBOUNCE_CYCLES)) u_release (
    .clk(clk), .rst(rst), .clear(state != WAIT_RELEASE), .match(&row_s2), .done(rel_done)
  );

`ifdef KEYPAD_REPEAT_EN
  keypad_stable_cnt #(.N(REPEAT_CYCLES)) u_repeat (
    .clk(clk), .rst(rst), .clear(state != WAIT_RELEASE), .match(!(&row_s2)), .done(rep_done)
  );
`else
  assign rep_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      row_s1     <= '1;
      row_s2     <= '1;
      pat        <= '1;
      col        <= 2'd0;
      row_idx    <= 2'd0;
      scan_cnt   <= '0;
      o_col      <= 4'b1110;
      o_send     <= 1'b0;
      o_data     <= '0;
      o_key_down <= 1'b0;
    end else begin
      row_s1 <= i_row;
      row_s2 <= row_s1;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (&row_s2) begin
              col   <= col + 2'd1;
              o_col <= col_drive(col + 2'd1);
            end else begin
              row_idx <= low_row(row_s2);
              pat     <= row_s2;
              state   <= DEBOUNCE;
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_ONE;
          end
        end
        DEBOUNCE: begin
          // A glitch moves on to the next column rather than rescanning this one.
          if (row_s2 != pat) begin
            col   <= col + 2'd1;
            o_col <= col_drive(col + 2'd1);
            state <= SCAN;
          end else if (press_done) begin
            o_data     <= key_code(row_idx, col);
            o_send     <= 1'b1;
            o_key_down <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (i_proc) begin
            o_send <= 1'b0;
            state  <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (rel_done) begin
            o_key_down <= 1'b0;
            col        <= col + 2'd1;
            o_col      <= col_drive(col + 2'd1);
            state      <= SCAN;
          end else if (rep_done) begin
            o_send <= 1'b1;
            state  <= WAIT_ACK;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule
